// File: rtl/rc4_pkg.sv
// Shared types and character constants for the RC4 message checker.
// Holds the checker FSM encoding and the legal-byte comparator.
package rc4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int         MSG_LEN    = 32;
    localparam logic [7:0] LO_CHAR    = 8'd97;
    localparam logic [7:0] HI_CHAR    = 8'd122;
    localparam logic [7:0] SPACE_CHAR = 8'd32;

    function automatic logic is_legal_char(
        input logic [7:0] c,
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic [7:0] sp
    );
        return ((c >= lo) && (c <= hi)) || (c == sp);
    endfunction

endpackage

// File: rtl/msg_checker_rd_tag_pipe.sv
// Read tag shift register: tracks (valid, index) of each issued read
// until its data returns from the RAM.
module rd_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [IDX_W-1:0] push_index,
    output logic             ret_valid,
    output logic [IDX_W-1:0] ret_index
);

    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx[i] <= '0;
            end
        end else begin
            vld[0] <= push_valid;
            idx[0] <= push_index;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign ret_valid = vld[DEPTH-1];
    assign ret_index = idx[DEPTH-1];

endmodule

// File: rtl/msg_checker.sv
// Reads the candidate plaintext back from message RAM and reports
// whether every byte is a lowercase letter or a space.
module msg_checker #(
    parameter int         MSG_LEN    = rc4_pkg::MSG_LEN,
    parameter int         ADDR_W     = 5,
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] LO_CHAR    = rc4_pkg::LO_CHAR,
    parameter logic [7:0] HI_CHAR    = rc4_pkg::HI_CHAR,
    parameter logic [7:0] SPACE_CHAR = rc4_pkg::SPACE_CHAR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_check,
    input  logic [7:0]        ram_q,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_rden,
    output logic              busy,
    output logic              done_checking,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_index,
    output logic [7:0]        fail_byte
);

    import rc4_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

    state_t            state;
    logic              ret_valid;
    logic [ADDR_W-1:0] ret_index;
    logic              ret_legal;
    logic              checking;
    logic              abort;
    logic              last_ok;

    assign ret_legal = is_legal_char(ram_q, LO_CHAR,
                                     HI_CHAR, SPACE_CHAR);
    assign checking  = (state == ISSUE) || (state == DRAIN);
    assign abort     = checking && ret_valid && !ret_legal;
    assign last_ok   = checking && ret_valid && ret_legal
                       && (ret_index == LAST);

    // Tags follow the registered read request, so they line up with
    // the RAM's view of the address.
    rd_tag_pipe #(
        .DEPTH (RD_LATENCY),
        .IDX_W (ADDR_W)
    ) u_tag_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (abort),
        .push_valid (ram_rden),
        .push_index (ram_address),
        .ret_valid  (ret_valid),
        .ret_index  (ret_index)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            ram_address   <= '0;
            ram_rden      <= 1'b0;
            busy          <= 1'b0;
            done_checking <= 1'b0;
            pass          <= 1'b0;
            fail_index    <= '0;
            fail_byte     <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_checking <= 1'b0;
                    if (start_check) begin
                        state       <= ISSUE;
                        ram_address <= '0;
                        ram_rden    <= 1'b1;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        fail_index  <= '0;
                        fail_byte   <= 8'd0;
                    end
                end
                ISSUE, DRAIN: begin
                    unique case (1'b1)
                        abort: begin
                            fail_index    <= ret_index;
                            fail_byte     <= ram_q;
                            pass          <= 1'b0;
                            ram_rden      <= 1'b0;
                            done_checking <= 1'b1;
                            state         <= DONE;
                        end
                        last_ok: begin
                            pass          <= 1'b1;
                            ram_rden      <= 1'b0;
                            done_checking <= 1'b1;
                            state         <= DONE;
                        end
                        default: begin
                            if (state == ISSUE) begin
                                if (ram_address == LAST) begin
                                    ram_rden <= 1'b0;
                                    state    <= DRAIN;
                                end else begin
                                    ram_address <= ram_address + 1'b1;
                                end
                            end
                        end
                    endcase
                end
                DONE: begin
                    done_checking <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_checker.sv
// Directed bench for msg_checker: three instances cover read latency
// 1 and 2 and a one-byte message.
module tb_msg_checker;

    typedef struct {
        int         inst;
        logic [7:0] fill;
        int         bad_pos;
        logic [7:0] bad_val;
        bit         exp_pass;
        int         exp_idx;
        logic [7:0] exp_byte;
        int         exp_edge;
        int         exp_nrd;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic st1, st2, st3;
    logic [7:0] q1, q2, q2a, q3;
    logic [4:0] addr1, addr2, fidx1, fidx2;
    logic [0:0] addr3, fidx3;
    logic rden1, rden2, rden3;
    logic busy1, busy2, busy3;
    logic done1, done2, done3;
    logic pass1, pass2, pass3;
    logic [7:0] fbyte1, fbyte2, fbyte3;

    logic [7:0] mem [32];
    int cur_inst;
    int ecnt = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic       m_rden, m_busy, m_done, m_pass;
    logic [7:0] m_addr, m_fidx, m_fbyte;

    vec_t  tbl [14];
    string txt = "hello world abcdefghijklmnopqrst";

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    always_ff @(posedge clk) begin
        if (rden1) q1 <= mem[addr1];
        if (rden2) q2a <= mem[addr2];
        q2 <= q2a;
        if (rden3) q3 <= mem[int'(addr3)];
    end

    msg_checker #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start_check(st1),
        .ram_q(q1), .ram_address(addr1), .ram_rden(rden1),
        .busy(busy1), .done_checking(done1), .pass(pass1),
        .fail_index(fidx1), .fail_byte(fbyte1)
    );

    msg_checker #(.RD_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start_check(st2),
        .ram_q(q2), .ram_address(addr2), .ram_rden(rden2),
        .busy(busy2), .done_checking(done2), .pass(pass2),
        .fail_index(fidx2), .fail_byte(fbyte2)
    );

    msg_checker #(.MSG_LEN(1), .ADDR_W(1), .RD_LATENCY(1)) dut3 (
        .clk(clk), .reset_n(reset_n), .start_check(st3),
        .ram_q(q3), .ram_address(addr3), .ram_rden(rden3),
        .busy(busy3), .done_checking(done3), .pass(pass3),
        .fail_index(fidx3), .fail_byte(fbyte3)
    );

    always_comb begin
        m_rden = rden1; m_busy = busy1; m_done = done1;
        m_pass = pass1; m_fbyte = fbyte1;
        m_addr = {3'b0, addr1}; m_fidx = {3'b0, fidx1};
        if (cur_inst == 1) begin
            m_rden = rden2; m_busy = busy2; m_done = done2;
            m_pass = pass2; m_fbyte = fbyte2;
            m_addr = {3'b0, addr2}; m_fidx = {3'b0, fidx2};
        end else if (cur_inst == 2) begin
            m_rden = rden3; m_busy = busy3; m_done = done3;
            m_pass = pass3; m_fbyte = fbyte3;
            m_addr = {7'b0, addr3}; m_fidx = {7'b0, fidx3};
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_start(input int i, input logic v);
        case (i)
            0: st1 = v;
            1: st2 = v;
            default: st3 = v;
        endcase
    endtask

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < 32; i++) begin
            mem[i] = (v.fill == 8'd0) ? txt[i] : v.fill;
        end
        if (v.bad_pos >= 0) mem[v.bad_pos] = v.bad_val;
    endtask

    task automatic run_vec(input int id, input vec_t v, input bit poke);
        int base, nrd, ndone, dedge;
        bit seq_ok;
        string p;
        p = $sformatf("v%0d", id);
        load_mem(v);
        cur_inst = v.inst;
        set_start(v.inst, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(v.inst, 1'b0);
        base = ecnt;
        chk({p, " clear"}, {14'd0, m_busy, m_pass, m_fidx, m_fbyte},
            {14'd0, 1'b1, 1'b0, 16'h0});
        nrd = 0; ndone = 0; dedge = -1; seq_ok = 1;
        for (int c = 0; c < 60; c++) begin
            if (poke) set_start(v.inst, c == 5);
            if (m_rden) begin
                if (m_addr != nrd[7:0]) seq_ok = 0;
                nrd++;
            end
            if (m_done) begin
                ndone++;
                dedge = ecnt - base;
                break;
            end
            @(negedge clk);
        end
        set_start(v.inst, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m_done) ndone++;
            if (m_rden) nrd++;
        end
        chk({p, " done_edge"}, dedge, v.exp_edge);
        chk({p, " ndone"}, ndone, 1);
        chk({p, " pass"}, {31'd0, m_pass}, {31'd0, v.exp_pass});
        chk({p, " fail_index"}, {24'd0, m_fidx}, v.exp_idx);
        chk({p, " fail_byte"}, {24'd0, m_fbyte}, {24'd0, v.exp_byte});
        chk({p, " nreads"}, nrd, v.exp_nrd);
        chk({p, " addr_seq"}, {31'd0, seq_ok}, 32'd1);
        chk({p, " busy_after"}, {31'd0, m_busy}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base, nd, nr, e1, e2;
        logic b34;
        tbl[0]  = '{0, 8'h00, -1, 8'h00, 1, 0,  8'h00, 33, 32};
        tbl[1]  = '{0, 8'h00,  5, 8'h41, 0, 5,  8'h41,  7,  7};
        tbl[2]  = '{0, 8'h00,  0, 8'h7B, 0, 0,  8'h7B,  2,  2};
        tbl[3]  = '{0, 8'h00,  0, 8'h60, 0, 0,  8'h60,  2,  2};
        tbl[4]  = '{0, 8'h61, -1, 8'h00, 1, 0,  8'h00, 33, 32};
        tbl[5]  = '{0, 8'h7A, -1, 8'h00, 1, 0,  8'h00, 33, 32};
        tbl[6]  = '{0, 8'h20, -1, 8'h00, 1, 0,  8'h00, 33, 32};
        tbl[7]  = '{1, 8'h00, -1, 8'h00, 1, 0,  8'h00, 34, 32};
        tbl[8]  = '{1, 8'h00, 31, 8'h00, 0, 31, 8'h00, 34, 32};
        tbl[9]  = '{0, 8'h00, 31, 8'h7B, 0, 31, 8'h7B, 33, 32};
        tbl[10] = '{0, 8'h00, 10, 8'h80, 0, 10, 8'h80, 12, 12};
        tbl[11] = '{1, 8'h00,  2, 8'h5B, 0, 2,  8'h5B,  5,  5};
        tbl[12] = '{2, 8'h71, -1, 8'h00, 1, 0,  8'h00,  2,  1};
        tbl[13] = '{2, 8'h71,  0, 8'h51, 0, 0,  8'h51,  2,  1};

        reset_n = 1'b0;
        st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
        cur_inst = 0;
        load_mem(tbl[0]);
        repeat (3) @(negedge clk);
        chk("rst dut1", {rden1, busy1, done1, pass1, addr1,
            fidx1, fbyte1}, 32'd0);
        chk("rst dut2", {rden2, busy2, done2, pass2, addr2,
            fidx2, fbyte2}, 32'd0);
        chk("rst dut3", {rden3, busy3, done3, pass3, addr3,
            fidx3, fbyte3}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_vec(i, tbl[i], 1'b0);
        end

        // Reset sampled at E10 while the sweep is under way.
        cur_inst = 0;
        load_mem(tbl[0]);
        st1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st1 = 1'b0;
        base = ecnt;
        while (ecnt - base < 9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst outs", {rden1, busy1, done1, pass1, addr1,
            fidx1, fbyte1}, 32'd0);
        nd = 0; nr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done1) nd++;
            if (rden1) nr++;
        end
        chk("midrst ndone", nd, 0);
        chk("midrst nreads", nr, 0);
        run_vec(20, tbl[0], 1'b0);

        run_vec(21, tbl[0], 1'b1);

        // Held start: checks repeat every 35 edges.
        cur_inst = 0;
        load_mem(tbl[0]);
        st1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        base = ecnt;
        nd = 0; nr = 0; e1 = -1; e2 = -1; b34 = 1'b1;
        for (int c = 0; c < 104; c++) begin
            if (rden1) nr++;
            if (done1) begin
                nd++;
                if (e1 < 0) e1 = ecnt - base;
                else if (e2 < 0) e2 = ecnt - base;
            end
            if (c == 34) b34 = busy1;
            @(negedge clk);
        end
        st1 = 1'b0;
        chk("held ndone", nd, 3);
        chk("held edge1", e1, 33);
        chk("held edge2", e2, 68);
        chk("held nreads", nr, 96);
        chk("held busy_gap", {31'd0, b34}, 32'd0);
        repeat (50) @(negedge clk);
        chk("held pass", {31'd0, pass1}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/msg_checker.md
Name: msg_checker

Overview:
- Read-side companion to the S-box/message RAM writers. After the decrypt stage has written a candidate plaintext into the message RAM, this block reads it back byte by byte and decides whether the plaintext is legal (lowercase 'a'..'z' or space).
- It issues sequential reads, pipelines them against the RAM read latency, and aborts on the first illegal byte.
- It reports pass/fail, the failing index and the failing byte to the key-search controller.

Parameters:
- MSG_LEN, 32, number of message bytes checked (addresses 0..MSG_LEN-1), range 1..256.
- ADDR_W, 5, RAM address width; requires 2^ADDR_W >= MSG_LEN.
- RD_LATENCY, 1, cycles from address presented to q valid; legal values 1 and 2.
- LO_CHAR, 8'd97, lowest legal letter ('a').
- HI_CHAR, 8'd122, highest legal letter ('z').
- SPACE_CHAR, 8'd32, additional legal byte (' ').

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start_check  in  1  request a check; sampled only in IDLE.
- ram_q  in  8  read data from message RAM.
- ram_address  out  ADDR_W  read address.
- ram_rden  out  1  read enable.
- busy  out  1  high from the cycle after start is accepted until done.
- done_checking  out  1  one-cycle pulse when the verdict is valid.
- pass  out  1  1 = all bytes legal; held until next accepted start.
- fail_index  out  ADDR_W  index of first illegal byte; 0 on pass; held.
- fail_byte  out  8  value of first illegal byte; 0 on pass; held.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset_n is synchronous and active-low: on a clk edge with reset_n=0 all state is cleared.
  - Reset values: state=IDLE, ram_address=0, ram_rden=0, busy=0, done_checking=0, pass=0, fail_index=0, fail_byte=0, internal counters 0, tag pipeline empty.
- States:
  - IDLE: start_check=1 → ISSUE; clear pass, fail_index and fail_byte.
  - ISSUE: drive ram_address=k and ram_rden=1 for k=0..MSG_LEN-1, one address per cycle.
    - Each issued read pushes (valid, k) into a RD_LATENCY-deep tag shift register.
    - After k=MSG_LEN-1 is issued → DRAIN.
  - DRAIN: ram_rden=0; wait for outstanding tags to retire.
  - DONE: one cycle; done_checking=1, busy=0 next cycle; → IDLE.
- Checking:
  - When a tag retires, ram_q is compared: legal iff (LO_CHAR <= q <= HI_CHAR) or q == SPACE_CHAR.
  - Comparisons are unsigned 8-bit.
- Abort on first failure:
  - The first illegal byte registers fail_index=tag index and fail_byte=ram_q, sets pass=0, flushes the tag pipeline, drops ram_rden and goes to DONE.
  - Bytes already in flight are discarded.
- Pass: the last index (MSG_LEN-1) retires legal → pass=1, then DONE.
- Timing:
  - Start sampled at edge E0; address k is presented after edge Ek.
  - Byte k is checked at edge E(k+RD_LATENCY+1).
  - done_checking is high in the cycle after E(k_fail+RD_LATENCY+1) on failure, or after E(MSG_LEN+RD_LATENCY) on pass.
  - With defaults, pass → done after E33.
- Boundary conditions:
  - start_check while busy: ignored, no restart.
  - start_check held high through DONE: a new check begins from IDLE on the next cycle.
  - MSG_LEN=1: a single read, then the verdict.
  - Address counter must not wrap: stop issuing at MSG_LEN-1 even when 2^ADDR_W == MSG_LEN.
  - reset_n low mid-check: immediate return to IDLE with reset values; no done pulse.
  - ram_q is don't-care except on tag-retire cycles.

Decomposition:
- Shared package rc4_pkg:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - character constants LO_CHAR, HI_CHAR, SPACE_CHAR;
  - MSG_LEN default.
- One natural sub-module, rd_tag_pipe: the RD_LATENCY-deep valid+index shift register with a synchronous flush input.
- The comparator stays inline as a function in rc4_pkg (is_legal_char).

Test Plan:
- RAM = "hello world abc..." (32 legal bytes), start pulse at E0, RD_LATENCY=1 → one done pulse after E33; pass=1, fail_index=0, fail_byte=0; ram_address sweeps 0..31 exactly once.
- Byte 5 = 8'h41 ('A'), others legal → done after E7; pass=0, fail_index=5, fail_byte=8'h41; no address beyond 6 issued after the abort edge.
- Byte 0 = 8'h7B ('{'), which sits just above 'z' → fail_index=0, fail_byte=8'h7B. Repeat with 8'h60 (just below 'a') → fail; with 8'h61, 8'h7A and 8'h20 in every position → pass.
- RD_LATENCY=2, all legal → done after E34. With byte 31 = 8'h00 → done after E34, fail_index=31.
- reset_n=0 for one cycle at E10 during ISSUE → all outputs at reset values, no done pulse. A new start then completes normally with pass=1.
- start_check held high continuously → back-to-back checks, each with exactly one done pulse. Pulsing start during ISSUE does not restart the address sweep.
